brew_sequencer: RTL and testbench

Drink-making back end that sits directly downstream of the vending control unit. It consumes the unit's `Making`/`Coffee` levels and the `LD_C`/`Kind` drink-select strobe, and drives the heater, pump and milk actuators for one cup. It returns the `Done` and `TakeOut` handshakes that move the control unit through its MAKE2 → MAKE3 → MAKE1 cup loop. One cup is brewed per `Making` assertion, and a cup-presence sensor gates all dispensing.

---
 rtl/brew_sequencer_if.sv | 26 ++
 rtl/brew_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_brew_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/brew_sequencer_if.sv
// brew_sequencer_if: control-unit <-> brew back-end signal bundle.
// master = vending control unit side, slave = brew_sequencer side.
interface brew_sequencer_if;
    logic       LD_C;       // drink-select strobe
    logic [1:0] Kind;       // 2'b10 latte, anything else americano
    logic       Making;     // level: brew one cup
    logic       Coffee;     // level: cup ready for pickup
    logic       CupSensor;  // 1 = cup present under the spout
    logic       Heater;
    logic       Pump;
    logic       Milk;
    logic       Done;       // held until Making falls
    logic       TakeOut;    // one-cycle pulse on cup removal
    logic       Busy;       // sequencer not idle
    logic       Fault;      // brew paused, cup missing

    modport master (
        output LD_C, Kind, Making, Coffee, CupSensor,
        input  Heater, Pump, Milk, Done, TakeOut, Busy, Fault
    );

    modport slave (
        input  LD_C, Kind, Making, Coffee, CupSensor,
        output Heater, Pump, Milk, Done, TakeOut, Busy, Fault
    );
endinterface

// File: rtl/brew_sequencer.sv
// brew_sequencer: drives heater, pump and milk for one cup per Making request,
// pauses (and later resumes from where it stopped) while the cup is missing,
// and returns the Done / TakeOut handshakes to the vending control unit.
// Optional feature: define BREW_MILK_EN to build the MILK stage and latte
// routing; without it Milk is tied low and a latte selection brews americano.
module brew_sequencer #(
    parameter logic [15:0] HEAT_CYC = 16'd200,  // heater-on clocks, >= 1
    parameter logic [15:0] PUMP_CYC = 16'd400,  // pump-on clocks, >= 1
    parameter logic [15:0] MILK_CYC = 16'd300,  // milk-valve clocks, >= 1
    parameter logic [15:0] DEB_CYC  = 16'd50    // cup-removed debounce clocks, >= 1
) (
    input logic             CLK,
    input logic             RST,
    brew_sequencer_if.slave bus
);

    // Explicit encodings keep the remaining states stable when MILK is
    // compiled out.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAT  = 3'd1,
        ST_PUMP  = 3'd2,
`ifdef BREW_MILK_EN
        ST_MILK  = 3'd3,
`endif
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5,
        ST_SERVE = 3'd6,
        ST_TAKE  = 3'd7
    } state_t;

    state_t      state_q, state_d;
    state_t      saved_state_q, saved_state_d;  // stage interrupted by PAUSE
    logic [15:0] count_q, count_d;              // tick count within a timed stage
    logic [15:0] saved_count_q, saved_count_d;  // count to resume from
    logic [15:0] deb_q, deb_d;                  // consecutive cup-removed cycles
    logic [1:0]  kind_q;                        // latched drink kind

    logic [15:0] stage_len;
    state_t      stage_next;
    logic [15:0] count_inc;
    logic        stage_end;

    // Kind latch: follows every LD_C strobe, including during a brew.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            kind_q <= 2'b01;
        end else if (bus.LD_C) begin
            kind_q <= bus.Kind;
        end
    end

    // State, tick counter, saved context and debounce counter.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state is updated with <= so every register samples
        // the pre-edge values, independent of statement order.
        if (RST) begin
            state_q       <= ST_IDLE;
            // NOTE: the saved context is reset along with the state so a
            // PAUSE can never resume into an undefined stage or count.
            saved_state_q <= ST_HEAT;
            count_q       <= '0;
            saved_count_q <= '0;
            deb_q         <= '0;
        end else begin
            state_q       <= state_d;
            saved_state_q <= saved_state_d;
            count_q       <= count_d;
            saved_count_q <= saved_count_d;
            deb_q         <= deb_d;
        end
    end

    // Length and successor of the timed stage currently running.
    always_comb begin
        stage_len  = HEAT_CYC;
        stage_next = ST_PUMP;
        case (state_q)
            ST_PUMP: begin
                stage_len = PUMP_CYC;
`ifdef BREW_MILK_EN
                // Latte routing uses the latch value present at this edge.
                stage_next = (kind_q == 2'b10) ? ST_MILK : ST_DONE;
`else
                stage_next = ST_DONE;
`endif
            end
`ifdef BREW_MILK_EN
            ST_MILK: begin
                stage_len  = MILK_CYC;
                stage_next = ST_DONE;
            end
`endif
            default: ;
        endcase
    end

    // Saturating increment keeps the counter from wrapping after a pause
    // taken on a terminal count.
    assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    // ">=" lets a stage resumed past its terminal count finish after one cycle.
    assign stage_end = (count_q >= stage_len - 16'd1);

    // Next-state logic: counters clear on state entry unless restored from PAUSE.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d       = state_q;
        saved_state_d = saved_state_q;
        saved_count_d = saved_count_q;
        count_d       = '0;
        deb_d         = '0;

        case (state_q)
            ST_IDLE: begin
                // Making with no cup simply waits here for the next cup.
                if (bus.Making && bus.CupSensor) begin
                    state_d = ST_HEAT;
                end
            end

`ifdef BREW_MILK_EN
            ST_HEAT, ST_PUMP, ST_MILK: begin
`else
            ST_HEAT, ST_PUMP: begin
`endif
                if (!bus.Making) begin
                    // Control unit re-initialised: abort without Done.
                    state_d = ST_IDLE;
                end else if (!bus.CupSensor) begin
                    // Cup missing wins over the terminal count; the cycle just
                    // spent in the stage still counts.
                    state_d       = ST_PAUSE;
                    saved_state_d = state_q;
                    saved_count_d = count_inc;
                end else if (stage_end) begin
                    state_d = stage_next;
                end else begin
                    count_d = count_inc;
                end
            end

            ST_PAUSE: begin
                if (!bus.Making) begin
                    state_d = ST_IDLE;
                end else if (bus.CupSensor) begin
                    state_d = saved_state_q;
                    count_d = saved_count_q;
                end
            end

            ST_DONE: begin
                if (!bus.Making) begin
                    state_d = ST_SERVE;
                end
            end

            ST_SERVE: begin
                if (deb_q == DEB_CYC) begin
                    state_d = ST_TAKE;
                end else if (bus.CupSensor) begin
                    deb_d = '0;
                end else if (bus.Coffee) begin
                    deb_d = deb_q + 16'd1;
                end else begin
                    deb_d = deb_q;
                end
            end

            ST_TAKE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state register only, so an asynchronous
    // reset drops every actuator at once.
    assign bus.Heater  = (state_q == ST_HEAT);
    assign bus.Pump    = (state_q == ST_PUMP);
    assign bus.Done    = (state_q == ST_DONE);
    assign bus.TakeOut = (state_q == ST_TAKE);
    assign bus.Busy    = (state_q != ST_IDLE);
    assign bus.Fault   = (state_q == ST_PAUSE);

`ifdef BREW_MILK_EN
    assign bus.Milk = (state_q == ST_MILK);
`else
    assign bus.Milk = 1'b0;

    // Without the milk stage the latch and MILK_CYC have no consumer.
    logic unused_cfg;
    assign unused_cfg = ^{kind_q, MILK_CYC};
`endif

endmodule

// File: tb/tb_brew_sequencer.sv
// tb_brew_sequencer: directed scenarios for brew_sequencer, every cycle
// compared against a progress-based behavioural model, plus hand-computed
// latency and duration checks that pin the model itself.
module tb_brew_sequencer;

    localparam int H = 4;
    localparam int P = 6;
    localparam int M = 3;
    localparam int D = 2;
`ifdef BREW_MILK_EN
    localparam bit MILK_EN = 1'b1;
`else
    localparam bit MILK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    brew_sequencer_if bif ();

    brew_sequencer #(
        .HEAT_CYC(16'd4),
        .PUMP_CYC(16'd6),
        .MILK_CYC(16'd3),
        .DEB_CYC (16'd2)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bif)
    );

    // ---------------- behavioural model ----------------
    // A brew is a sequence of H heat, P pump (and M milk) work cycles; prog is
    // the index of the work cycle being performed. A pause taken exactly on a
    // stage end costs one extra cycle in that stage after resuming (stuck).
    typedef enum int {PH_IDLE, PH_BREW, PH_PAUSE, PH_DONE, PH_SERVE, PH_TAKE} phase_t;
    typedef struct {
        phase_t     phase;
        int         prog;
        bit         stuck;
        bit         milk_sel;
        int         deb;
        logic [1:0] kind;
    } model_t;

    function automatic model_t model_reset();
        model_t s;
        s.phase = PH_IDLE; s.prog = 0; s.stuck = 1'b0; s.milk_sel = 1'b0;
        s.deb = 0; s.kind = 2'b01;
        return s;
    endfunction

    function automatic bit at_stage_end(int p);
        return (p == H) || (p == H + P) || (p == H + P + M);
    endfunction

    function automatic model_t model_step(model_t s, logic making, logic cup,
                                          logic coffee, logic ld, logic [1:0] kind);
        model_t n;
        n = s;
        case (s.phase)
            PH_IDLE:
                if (making && cup) begin
                    n.phase = PH_BREW; n.prog = 0; n.stuck = 1'b0; n.milk_sel = 1'b0;
                end
            PH_BREW:
                if (!making) begin
                    n.phase = PH_IDLE;
                end else if (!cup) begin
                    if (!s.stuck) begin
                        n.prog  = s.prog + 1;
                        n.stuck = at_stage_end(n.prog);
                    end
                    n.phase = PH_PAUSE;
                end else begin
                    if (!s.stuck) n.prog = s.prog + 1;
                    n.stuck = 1'b0;
                    if (n.prog == H + P) n.milk_sel = MILK_EN && (s.kind == 2'b10);
                    if ((n.prog == H + P && !n.milk_sel) || (n.prog == H + P + M && n.milk_sel))
                        n.phase = PH_DONE;
                end
            PH_PAUSE:
                if (!making) n.phase = PH_IDLE;
                else if (cup) n.phase = PH_BREW;
            PH_DONE:
                if (!making) begin
                    n.phase = PH_SERVE; n.deb = 0;
                end
            PH_SERVE:
                if (s.deb == D) n.phase = PH_TAKE;
                else if (cup) n.deb = 0;
                else if (coffee) n.deb = s.deb + 1;
            PH_TAKE:
                n.phase = PH_IDLE;
            default:
                n.phase = PH_IDLE;
        endcase
        if (ld) n.kind = kind;
        return n;
    endfunction

    // Expected {Heater, Pump, Milk, Done, TakeOut, Busy, Fault}.
    function automatic logic [6:0] model_out(model_t s);
        logic [6:0] o;
        int         q;
        o = '0;
        q = s.stuck ? s.prog - 1 : s.prog;
        case (s.phase)
            PH_BREW:
                if (q < H) o[6] = 1'b1;
                else if (q < H + P) o[5] = 1'b1;
                else o[4] = 1'b1;
            PH_PAUSE: o[0] = 1'b1;
            PH_DONE:  o[3] = 1'b1;
            PH_TAKE:  o[2] = 1'b1;
            default: ;
        endcase
        o[1] = (s.phase != PH_IDLE);
        return o;
    endfunction

    model_t m = model_reset();

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_step(m, bif.Making, bif.CupSensor, bif.Coffee, bif.LD_C, bif.Kind);
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int heat_tot = 0, pump_tot = 0, milk_tot = 0, fault_tot = 0, take_tot = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [6:0] dut_out();
        return {bif.Heater, bif.Pump, bif.Milk, bif.Done, bif.TakeOut, bif.Busy, bif.Fault};
    endfunction

    // One clock: outputs are compared 2 ns after the edge against the model.
    task automatic step();
        logic [6:0] act;
        logic [6:0] exp;
        @(posedge clk);
        #2;
        cyc++;
        act = dut_out();
        exp = model_out(m);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cycle %0d outputs {H,P,M,D,T,B,F}: got %b, expected %b", cyc, act, exp);
        end
        heat_tot  += int'(bif.Heater);
        pump_tot  += int'(bif.Pump);
        milk_tot  += int'(bif.Milk);
        fault_tot += int'(bif.Fault);
        take_tot  += int'(bif.TakeOut);
    endtask

    task automatic ld(input logic [1:0] k);
        bif.LD_C = 1'b1; bif.Kind = k;
        step();
        bif.LD_C = 1'b0;
    endtask

    // Raise Making and run until Done; done_e counts edges after leaving IDLE.
    task automatic brew(input int sw_at, input logic [1:0] sw_kind,
                        input int pull_at, input int pull_len,
                        output int done_e, output int heat, output int pump,
                        output int milk, output int fault);
        int h0, p0, m0, f0;
        h0 = heat_tot; p0 = pump_tot; m0 = milk_tot; f0 = fault_tot;
        done_e = -1;
        bif.Making = 1'b1;
        bif.CupSensor = 1'b1;
        for (int k = 1; k <= 60 && done_e < 0; k++) begin
            step();
            if (bif.Done) done_e = k - 1;
            bif.LD_C = (k == sw_at);
            if (k == sw_at) bif.Kind = sw_kind;
            if (k == pull_at) bif.CupSensor = 1'b0;
            if (k == pull_at + pull_len) bif.CupSensor = 1'b1;
        end
        bif.LD_C = 1'b0;
        heat = heat_tot - h0; pump = pump_tot - p0;
        milk = milk_tot - m0; fault = fault_tot - f0;
    endtask

    // Drop Making, then remove the cup (optionally after a one-cycle glitch).
    task automatic serve(input bit glitch);
        int t;
        int t0;
        t = -1;
        bif.Making = 1'b0;
        step();
        check("done falls on Making=0", int'(bif.Done), 0);
        check("busy while serving", int'(bif.Busy), 1);
        bif.Coffee = 1'b1;
        if (glitch) begin
            t0 = take_tot;
            bif.CupSensor = 1'b0;
            step();
            bif.CupSensor = 1'b1;
            repeat (4) step();
            check("no takeout on 1-cycle glitch", take_tot - t0, 0);
        end
        bif.CupSensor = 1'b0;
        for (int k = 1; k <= 20 && t < 0; k++) begin
            step();
            if (bif.TakeOut) t = k;
        end
        check("takeout edges after removal", t, 3);
        step();
        check("takeout is one cycle", int'(bif.TakeOut), 0);
        check("idle after takeout", int'(bif.Busy), 0);
        bif.CupSensor = 1'b1;
        bif.Coffee = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int de, nh, np, nm, nf;
        bif.LD_C = 1'b0; bif.Kind = 2'b01; bif.Making = 1'b0;
        bif.Coffee = 1'b0; bif.CupSensor = 1'b1;
        #1 rst = 1'b1;
        #12 rst = 1'b0;
        check("reset outputs", int'(dut_out()), 0);

        // Americano from the reset kind value.
        brew(0, 2'b00, 0, 0, de, nh, np, nm, nf);
        check("americano done edge", de, 10);
        check("americano heater cycles", nh, 4);
        check("americano pump cycles", np, 6);
        check("americano milk cycles", nm, 0);
        serve(1'b1);

        // Latte selected before the brew.
        ld(2'b10);
        brew(0, 2'b00, 0, 0, de, nh, np, nm, nf);
        check("latte done edge", de, MILK_EN ? 13 : 10);
        check("latte milk cycles", nm, MILK_EN ? 3 : 0);
        check("latte pump cycles", np, 6);
        serve(1'b0);

        // Americano latched, switched to latte during HEAT.
        ld(2'b01);
        brew(1, 2'b10, 0, 0, de, nh, np, nm, nf);
        check("mid-brew latte done edge", de, MILK_EN ? 13 : 10);
        serve(1'b0);

        // Undefined kind 2'b11 brews americano.
        ld(2'b11);
        brew(0, 2'b00, 0, 0, de, nh, np, nm, nf);
        check("kind 11 done edge", de, 10);
        check("kind 11 milk cycles", nm, 0);
        serve(1'b0);

        // Cup pulled for 5 cycles during PUMP.
        ld(2'b01);
        brew(0, 2'b00, 7, 5, de, nh, np, nm, nf);
        check("pause done edge", de, 15);
        check("pause fault cycles", nf, 5);
        check("pause pump cycles", np, 6);
        check("pause heater cycles", nh, 4);
        serve(1'b0);

        // Cup pulled on the HEAT terminal edge: one extra heat cycle.
        brew(0, 2'b00, 4, 1, de, nh, np, nm, nf);
        check("terminal pause done edge", de, 12);
        check("terminal pause heater cycles", nh, 5);
        check("terminal pause fault cycles", nf, 1);
        serve(1'b0);

        // Abort during HEAT.
        bif.Making = 1'b1;
        step();
        step();
        check("heating before abort", int'(bif.Heater), 1);
        bif.Making = 0;
        step();
        check("abort idle", int'(bif.Busy), 0);
        check("abort heater off", int'(bif.Heater), 0);
        repeat (3) step();
        check("abort no done", int'(bif.Done), 0);

        // Asynchronous reset between edges during HEAT.
        bif.Making = 1'b1;
        step();
        step();
        check("heating before reset", int'(bif.Heater), 1);
        #1 rst = 1'b1;
        #1;
        check("async reset heater", int'(bif.Heater), 0);
        check("async reset outputs", int'(dut_out()), 0);
        bif.Making = 1'b0;
        rst = 1'b0;
        repeat (3) step();
        check("idle after reset", int'(bif.Busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
